// File: rtl/registru_fifo_param.sv
// registru_fifo_param: parameterised synchronous FIFO with valid/ready handshakes,
// sticky overflow/underflow flags and a synchronous flush.
// All outputs come straight from flops; out_data is pre-computed for the next cycle.
// Optional feature: define REGISTRU_HIGHWATER_EN to add the max_count peak-occupancy output.
module registru_fifo_param #(
    parameter int unsigned WIDTH = 57,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clear_n,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic                     udf
`ifdef REGISTRU_HIGHWATER_EN
    ,
    output logic [$clog2(DEPTH):0]   max_count
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Elaboration-time guard on the legal parameter ranges
    if (WIDTH < 1 || WIDTH > 128) begin : g_bad_width
        $error("registru_fifo_param: WIDTH must be 1..128");
    end
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("registru_fifo_param: DEPTH must be a power of two in 2..16");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             do_push;
    logic             do_pop;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             ovf_nxt;
    logic             udf_nxt;
    logic             in_ready_nxt;
    logic             out_valid_nxt;
    logic [WIDTH-1:0] out_data_nxt;
`ifdef REGISTRU_HIGHWATER_EN
    logic [CNT_W-1:0] max_count_nxt;
`endif

    // Next-state computation for pointers, occupancy, flags and the output word
    always_comb begin
        do_push       = 1'b0;
        do_pop        = 1'b0;
        wr_ptr_nxt    = wr_ptr;
        rd_ptr_nxt    = rd_ptr;
        count_nxt     = count;
        ovf_nxt       = ovf;
        udf_nxt       = udf;
        in_ready_nxt  = 1'b1;
        out_valid_nxt = 1'b0;
        out_data_nxt  = '0;
`ifdef REGISTRU_HIGHWATER_EN
        max_count_nxt = max_count;
`endif

        if (flush) begin
            // Flush discards any same-cycle transfer and clears the sticky flags
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
            ovf_nxt    = 1'b0;
            udf_nxt    = 1'b0;
`ifdef REGISTRU_HIGHWATER_EN
            max_count_nxt = '0;
`endif
        end else begin
            do_push = in_valid && in_ready;
            do_pop  = out_valid && out_ready;
            // A refused push when full flags overflow even if a pop frees space this cycle
            if (in_valid && !in_ready) begin
                ovf_nxt = 1'b1;
            end
            if (out_ready && !out_valid) begin
                udf_nxt = 1'b1;
            end
            if (do_push) begin
                wr_ptr_nxt = wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_nxt = rd_ptr + PTR_W'(1);
            end
            count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
`ifdef REGISTRU_HIGHWATER_EN
            if (count_nxt > max_count) begin
                max_count_nxt = count_nxt;
            end
`endif
        end

        in_ready_nxt  = (count_nxt < CNT_W'(DEPTH));
        out_valid_nxt = (count_nxt != '0);

        // Head word for next cycle: bypass the incoming word when it lands at the new head
        if (out_valid_nxt) begin
            if (do_push && (wr_ptr == rd_ptr_nxt)) begin
                out_data_nxt = in_data;
            end else begin
                out_data_nxt = mem[rd_ptr_nxt];
            end
        end
    end

    // Control and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef REGISTRU_HIGHWATER_EN
            max_count <= '0;
`endif
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            ovf       <= ovf_nxt;
            udf       <= udf_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
`ifdef REGISTRU_HIGHWATER_EN
            max_count <= max_count_nxt;
`endif
        end
    end

    // Storage array; contents are never reset, only the pointers are
    always_ff @(posedge clk) begin
        if (clear_n && do_push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_registru_fifo_param.sv
// Directed self-checking bench for registru_fifo_param (WIDTH=57, DEPTH=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_registru_fifo_param;

    localparam int unsigned WIDTH = 57;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             clear_n = 1'b0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [2:0]       count;
    logic             ovf;
    logic             udf;
`ifdef REGISTRU_HIGHWATER_EN
    logic [2:0]       max_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [WIDTH-1:0] HI = 57'h100000000000000;

    registru_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .ovf       (ovf),
        .udf       (udf)
`ifdef REGISTRU_HIGHWATER_EN
        ,
        .max_count (max_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        clear_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        tick(); tick();
        clear_n = 1'b1;
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        n_tests++; if ({ovf, udf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b exp 00", {ovf, udf}); end
    endtask

    task automatic test_basic_order();
        logic [WIDTH-1:0] exp_d;
        out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty_valid got %b exp 0", out_valid); end
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = WIDTH'(i);
            tick();
            // first word visible right after the edge that pushed it
            if (i == 1) begin
                n_tests++; if (out_data !== WIDTH'(1) || out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency got %h/%b exp 1/1", out_data, out_valid); end
            end
        end
        in_valid = 1'b0;
        n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL basic_count3 got %0d exp 3", count); end
        n_tests++; if (out_data !== WIDTH'(1)) begin n_fail++; $display("FAIL basic_head got %h exp 1", out_data); end
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            exp_d = WIDTH'(i);
            n_tests++; if (out_data !== exp_d || out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_pop%0d got %h/%b exp %h/1", i, out_data, out_valid, exp_d); end
            tick();
        end
        out_ready = 1'b0;
        n_tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained got %0d/%b exp 0/0", count, out_valid); end
        n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL basic_empty_data got %h exp 0", out_data); end
        n_tests++; if (udf !== 1'b0) begin n_fail++; $display("FAIL basic_no_udf got %b exp 0", udf); end
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] exp_d;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = HI | WIDTH'(8'hA0 + i);
            tick();
            if (i == 3) begin
                n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_in_ready_full got %b exp 0", in_ready); end
                n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b exp 0", ovf); end
            end
        end
        in_valid = 1'b0;
        n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", ovf); end
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count got %0d exp 4", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_d = HI | WIDTH'(8'hA0 + i);
            n_tests++; if (out_data !== exp_d) begin n_fail++; $display("FAIL ovf_pop%0d got %h exp %h", i, out_data, exp_d); end
            tick();
        end
        out_ready = 1'b0;
        n_tests++; if (count !== 3'd0 || ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got cnt %0d ovf %b exp 0/1", count, ovf); end
        do_flush();
    endtask

    task automatic test_ovf_with_pop();
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = WIDTH'(8'h50 + i);
            tick();
        end
        // full: push refused, pop proceeds, overflow still flagged
        in_data = WIDTH'(8'h5F); out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovfpop_flag got %b exp 1", ovf); end
        n_tests++; if (count !== 3'd3 || in_ready !== 1'b1) begin n_fail++; $display("FAIL ovfpop_count got %0d/%b exp 3/1", count, in_ready); end
        n_tests++; if (out_data !== WIDTH'(8'h51)) begin n_fail++; $display("FAIL ovfpop_head got %h exp 51", out_data); end
        do_flush();
    endtask

    task automatic test_underflow_flush();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_tests++; if (udf !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL udf_set got udf %b cnt %0d exp 1/0", udf, count); end
        // make ovf set too so the flush clearing both is observable
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin in_data = WIDTH'(i); tick(); end
        in_valid = 1'b0;
        n_tests++; if ({ovf, udf} !== 2'b11) begin n_fail++; $display("FAIL udf_both_set got %b exp 11", {ovf, udf}); end
        do_flush();
        n_tests++; if ({ovf, udf} !== 2'b00) begin n_fail++; $display("FAIL flush_flags got %b exp 00", {ovf, udf}); end
        n_tests++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_state got %0d/%b/%b exp 0/0/1", count, out_valid, in_ready); end
    endtask

    task automatic test_flush_discard();
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin in_data = WIDTH'(8'h70 + i); tick(); end
        flush = 1'b1; in_data = WIDTH'(8'h7F); out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        n_tests++; if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL flush_discard got %0d/%b/%h exp 0/0/0", count, out_valid, out_data); end
        in_valid = 1'b1; in_data = WIDTH'(8'h33);
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_data !== WIDTH'(8'h33) || count !== 3'd1) begin n_fail++; $display("FAIL flush_first_after got %h/%0d exp 33/1", out_data, count); end
        do_flush();
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] exp_d;
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin in_data = HI | WIDTH'(8'hB0 + i); tick(); end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = HI | WIDTH'(8'hB2 + i);
            exp_d   = HI | WIDTH'(8'hB0 + i);
            n_tests++; if (out_data !== exp_d || count !== 3'd2) begin n_fail++; $display("FAIL b2b_%0d got %h/%0d exp %h/2", i, out_data, count, exp_d); end
            tick();
        end
        in_valid = 1'b0;
        n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count got %0d exp 2", count); end
        for (int i = 0; i < 2; i++) begin
            exp_d = HI | WIDTH'(8'hBA + i);
            n_tests++; if (out_data !== exp_d) begin n_fail++; $display("FAIL b2b_tail%0d got %h exp %h", i, out_data, exp_d); end
            tick();
        end
        out_ready = 1'b0;
        n_tests++; if (count !== 3'd0 || udf !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %0d/%b exp 0/0", count, udf); end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin in_data = WIDTH'(8'hC0 + i); tick(); end
        n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL rstmid_pre got %0d exp 3", count); end
        clear_n = 1'b0; in_data = WIDTH'(8'hDD); flush = 1'b0;
        tick();
        n_tests++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin n_fail++; $display("FAIL rstmid_state got %0d/%b/%b/%h exp 0/0/1/0", count, out_valid, in_ready, out_data); end
        clear_n = 1'b1; in_data = WIDTH'(8'hE1);
        tick();
        in_data = WIDTH'(8'hE2);
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_data !== WIDTH'(8'hE1) || count !== 3'd2) begin n_fail++; $display("FAIL rstmid_first got %h/%0d exp e1/2", out_data, count); end
        do_flush();
    endtask

`ifdef REGISTRU_HIGHWATER_EN
    task automatic test_highwater();
        n_tests++; if (max_count !== 3'd0) begin n_fail++; $display("FAIL hw_start got %0d exp 0", max_count); end
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin in_data = WIDTH'(i); tick(); end
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0; in_valid = 1'b1; in_data = WIDTH'(9);
        tick();
        in_valid = 1'b0;
        n_tests++; if (max_count !== 3'd3 || count !== 3'd2) begin n_fail++; $display("FAIL hw_peak got %0d/%0d exp 3/2", max_count, count); end
        do_flush();
        n_tests++; if (max_count !== 3'd0) begin n_fail++; $display("FAIL hw_flush got %0d exp 0", max_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_order();
        test_overflow();
        test_ovf_with_pop();
        test_underflow_flush();
        test_flush_discard();
        test_back_to_back();
        test_reset_mid();
`ifdef REGISTRU_HIGHWATER_EN
        test_highwater();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
